data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have CPU ports cpu_read (in, 1), cpu_write (in, 1), cpu_address (in, 16, word address), cpu_wdata (in, 16), cpu_rdata (out, 16) and cpu_ready (out, 1: access completes this cycle).
REQ-004 SHALL have memory ports d_readM (out, 1), d_writeM (out, 1), d_address (out, 16) and d_data (inout, 64: word n of the line in bits [16n+15:16n]).
REQ-005 SHALL use constants WORD_SIZE=16, FETCH_SIZE=64, LINES=4 and FILL_LAT=5, with no other parameters.

Function
REQ-006 SHALL be direct-mapped with 4 lines of 4 words: offset = addr[1:0], index = addr[3:2], tag = addr[15:4] (12 bits), plus one valid bit per line.
REQ-007 SHALL use write-through, no-write-allocate, with one outstanding request at a time.
REQ-008 SHALL use FSM states IDLE, FILL and WRITE; all memory-side outputs come from registered state and a 3-bit counter cnt.
REQ-009 In IDLE with cpu_read and a hit, SHALL assert cpu_ready combinationally in the same cycle with cpu_rdata = selected word (0-cycle hit), staying in IDLE.
REQ-010 In IDLE with cpu_read and a miss, SHALL go to FILL with cnt=0 and leave cpu_ready low.
REQ-011 In FILL, SHALL assert d_readM for cnt 0..3, deassert it at cnt 4, drive d_address = {addr[15:2],2'b00} and tri-state d_data.
REQ-012 In FILL, SHALL capture d_data into the line at the end of cnt 4, set tag/valid and return to IDLE; the re-lookup then hits, so miss-to-ready is 7 cycles including the request cycle.
REQ-013 In IDLE with cpu_write, SHALL go to WRITE with cnt=0 and latch the address and data.
REQ-014 In WRITE, SHALL assert d_writeM only at cnt 0, drive d_data with the full 64-bit line for cnt 0..3 (the line with the new word merged on a hit, zeros elsewhere on a miss), and assert cpu_ready at cnt 3 before returning to IDLE.
REQ-015 On a write hit, SHALL update the cached word at the end of cnt 3.
REQ-016 On a write miss, SHALL leave cache contents unchanged.
REQ-017 SHALL drive d_data to high-impedance outside WRITE.
REQ-018 SHALL never assert d_readM and d_writeM together.
REQ-019 SHALL treat cpu_read and cpu_write high together as a write.
REQ-020 SHALL require CPU request signals to stay stable until cpu_ready; changes before then are undefined.
REQ-021 SHALL issue a request arriving in the cycle after cpu_ready immediately, with no idle gap.

Reset
REQ-022 On reset_n low, SHALL immediately go to IDLE with cnt=0, all valid bits cleared, d_readM=0, d_writeM=0, d_data high-impedance and cpu_ready=0; cpu_rdata is don't-care.
REQ-023 Reset during FILL or WRITE SHALL abandon the transfer with no line written.
REQ-024 Data arrays need no reset.

Configuration
REQ-025 With DCACHE_STATS_EN defined, SHALL add outputs hit_count and miss_count (16 bits, saturating), counting read hits/misses once per request at IDLE lookup, cleared by reset.
REQ-026 Without DCACHE_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-027 SHALL place WORD_SIZE, FETCH_SIZE, line geometry and the FSM state encodings in the shared package/header, also used by Memory.
REQ-028 SHALL place tag/valid/data storage in sub-module data_cache_array (1 read port, 1 line-write port, 1 word-write port).

Verification
REQ-029 After reset, read 0x0001 -> d_readM for 4 cycles, cpu_ready in cycle 7, cpu_rdata=0x0001; then read 0x0002 -> ready same cycle, 0xFFFF.
REQ-030 Read 0x0000 then 0x0010 (same index, tag 0x001) -> two misses; a re-read of 0x0000 misses again and returns 0x9023.
REQ-031 Write 0x0001=0x1234 after the line is cached -> d_writeM one cycle, ready at cnt 3; read 0x0001 hits with 0x1234, and memory[1]=0x1234.
REQ-032 Write miss 0x0020=0xBEEF -> valid[0] unchanged; a following read 0x0020 misses and returns 0xBEEF.
REQ-033 Assert reset_n low at FILL cnt 2, then release -> outputs idle, read 0x0000 misses again.
REQ-034 With DCACHE_STATS_EN, the REQ-029 sequence gives hit_count=1 and miss_count=1.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared constants for the data cache and its memory: word/fetch widths,
// line geometry (4 lines x 4 words, direct mapped) and the FSM state encoding.
// Contains no logic beyond a word-select helper.
package data_cache_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int FETCH_SIZE     = 64;
    localparam int LINES          = 4;
    localparam int FILL_LAT       = 5;

    localparam int WORDS_PER_LINE = FETCH_SIZE / WORD_SIZE;
    localparam int OFF_W          = 2;
    localparam int IDX_W          = 2;
    localparam int TAG_W          = WORD_SIZE - IDX_W - OFF_W;
    localparam int CNT_W          = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Pick word 'off' out of a line (word n lives in bits [16n+15:16n]).
    function automatic logic [WORD_SIZE-1:0] get_word(input logic [FETCH_SIZE-1:0] line,
                                                      input logic [OFF_W-1:0]      off);
        return line[int'(off)*WORD_SIZE +: WORD_SIZE];
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// Tag/valid/data storage for the direct-mapped data cache.
// Ports: one combinational read port (valid, tag, whole line), one line-write
// port (fill: sets tag, valid and data) and one word-write port (write hit).
// Only the valid bits are reset; tag and data arrays are left uninitialised.
module data_cache_array
    import data_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [IDX_W-1:0]      rd_index_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [FETCH_SIZE-1:0] rd_line_o,
    input  logic                  lw_en_i,
    input  logic [IDX_W-1:0]      lw_index_i,
    input  logic [TAG_W-1:0]      lw_tag_i,
    input  logic [FETCH_SIZE-1:0] lw_line_i,
    input  logic                  ww_en_i,
    input  logic [IDX_W-1:0]      ww_index_i,
    input  logic [OFF_W-1:0]      ww_offset_i,
    input  logic [WORD_SIZE-1:0]  ww_word_i
);

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [FETCH_SIZE-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (lw_en_i) begin
            valid_q[lw_index_i] <= 1'b1;
        end
    end

    // Line and word writes come from different FSM states, so they never
    // collide on the same cycle.
    always_ff @(posedge clk) begin
        if (lw_en_i) begin
            tag_q[lw_index_i]  <= lw_tag_i;
            data_q[lw_index_i] <= lw_line_i;
        end
        if (ww_en_i) begin
            data_q[ww_index_i][int'(ww_offset_i)*WORD_SIZE +: WORD_SIZE] <= ww_word_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache, 4 lines x 4 words.
// Read hit: 0 cycles (cpu_ready same cycle); read miss: 7 cycles; write: 5 cycles.
// One outstanding request; CPU holds request stable until cpu_ready.
// Ports: clk/reset_n; CPU side cpu_read/cpu_write/cpu_address/cpu_wdata ->
// cpu_rdata/cpu_ready; memory side d_readM/d_writeM/d_address, bidirectional d_data.
// Optional macro DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module data_cache
    import data_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [WORD_SIZE-1:0]  cpu_address,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic [WORD_SIZE-1:0]  cpu_rdata,
    output logic                  cpu_ready,
    output logic                  d_readM,
    output logic                  d_writeM,
    output logic [WORD_SIZE-1:0]  d_address,
    inout  wire  [FETCH_SIZE-1:0] d_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;

    logic [WORD_SIZE-1:0]  lookup_addr;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [FETCH_SIZE-1:0] rd_line;
    logic                  hit;
    logic                  lw_en;
    logic                  ww_en;
    logic                  d_drive;
    logic [FETCH_SIZE-1:0] wline;

    // In IDLE the lookup uses the live CPU address (0-cycle hit); during a
    // transfer it uses the latched one.
    assign lookup_addr = (state_q == IDLE) ? cpu_address : addr_q;
    assign hit         = rd_valid && (rd_tag == lookup_addr[WORD_SIZE-1:IDX_W+OFF_W]);
    assign cpu_rdata   = get_word(rd_line, lookup_addr[OFF_W-1:0]);

    data_cache_array u_array (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_index_i  (lookup_addr[IDX_W+OFF_W-1:OFF_W]),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_line_o   (rd_line),
        .lw_en_i     (lw_en),
        .lw_index_i  (addr_q[IDX_W+OFF_W-1:OFF_W]),
        .lw_tag_i    (addr_q[WORD_SIZE-1:IDX_W+OFF_W]),
        .lw_line_i   (d_data),
        .ww_en_i     (ww_en),
        .ww_index_i  (addr_q[IDX_W+OFF_W-1:OFF_W]),
        .ww_offset_i (addr_q[OFF_W-1:0]),
        .ww_word_i   (wdata_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Write-through line image: the cached line with the new word merged on a
    // hit, otherwise the new word alone with zeros around it.
    always_comb begin
        wline = hit ? rd_line : '0;
        wline[int'(addr_q[OFF_W-1:0])*WORD_SIZE +: WORD_SIZE] = wdata_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cpu_ready = 1'b0;
        d_readM   = 1'b0;
        d_writeM  = 1'b0;
        d_address = '0;
        d_drive   = 1'b0;
        lw_en     = 1'b0;
        ww_en     = 1'b0;
        case (state_q)
            IDLE: begin
                // A simultaneous read+write is handled as a write.
                if (cpu_write) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                    addr_d  = cpu_address;
                    wdata_d = cpu_wdata;
                end else if (cpu_read) begin
                    addr_d = cpu_address;
                    if (hit) begin
                        cpu_ready = 1'b1;
                    end else begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
            end
            FILL: begin
                d_address = {addr_q[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                d_readM   = (cnt_q < CNT_W'(WORDS_PER_LINE));
                if (cnt_q == CNT_W'(FILL_LAT - 1)) begin
                    // Line arrives on the last fill cycle; the IDLE re-lookup hits.
                    lw_en   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                d_address = addr_q;
                d_drive   = 1'b1;
                d_writeM  = (cnt_q == '0);
                if (cnt_q == CNT_W'(WORDS_PER_LINE - 1)) begin
                    cpu_ready = 1'b1;
                    ww_en     = hit;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign d_data = d_drive ? wline : {FETCH_SIZE{1'bz}};

`ifdef DCACHE_STATS_EN
    logic        refill_q;
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic        rd_lookup;

    // The hit right after a fill belongs to the request already counted as a miss.
    assign rd_lookup = (state_q == IDLE) && cpu_read && !cpu_write && !refill_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            refill_q <= lw_en;
            if (rd_lookup && hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (rd_lookup && !hit && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random traffic
// against a flat-memory reference with a per-index tag/valid model.
// Also contains the backing memory that answers fills and takes write-through.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [15:0] cpu_wdata = '0;
    wire  [15:0] cpu_rdata;
    wire         cpu_ready;
    wire         d_readM;
    wire         d_writeM;
    wire  [15:0] d_address;
    wire  [63:0] d_data;
`ifdef DCACHE_STATS_EN
    wire  [15:0] hit_count;
    wire  [15:0] miss_count;
`endif

    always #5 clk = ~clk;

    data_cache dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .d_readM     (d_readM),
        .d_writeM    (d_writeM),
        .d_address   (d_address),
        .d_data      (d_data)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] init_word(input int i);
        case (i)
            0:       return 16'h9023;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            default: return 16'(i * 40503 + 7);
        endcase
    endfunction

    // ---------------- backing memory (256 words) ----------------
    logic [15:0] mem [256];
    bit          mem_init_done = 1'b0;
    logic        mem_drive = 1'b0;
    logic [7:0]  mem_base;

    assign mem_base = {d_address[7:2], 2'b00};
    // Memory answers a fill while d_readM is (or just was) high.
    assign d_data = mem_drive ? {mem[mem_base + 8'd3], mem[mem_base + 8'd2],
                                 mem[mem_base + 8'd1], mem[mem_base]} : 64'bz;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (d_writeM) begin
            mem[d_address[7:0]] <= d_data[16*d_address[1:0] +: 16];
        end
        mem_drive <= d_readM;
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [256];
    bit          mvalid [4];
    logic [11:0] mtag   [4];
    int          mhits = 0;
    int          mmiss = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
        mhits = 0;
        mmiss = 0;
    endtask

    // Issue one CPU access starting at posedge+1 and check it to completion.
    task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [15:0] wd, input string tag);
        int          idx;
        bit          hit;
        int          exp_lat;
        int          cyc;
        int          nrd;
        int          nwr;
        int          both;
        logic [63:0] exp_line;
        logic [15:0] got;
        idx  = int'(a[3:2]);
        hit  = mvalid[idx] && (mtag[idx] == a[15:4]);
        cyc  = 0;
        nrd  = 0;
        nwr  = 0;
        both = 0;
        got  = '0;
        exp_line = '0;
        if (hit) begin
            for (int w = 0; w < 4; w++)
                exp_line[16*w +: 16] = ref_mem[{a[7:2], 2'(w)}];
        end
        exp_line[16*a[1:0] +: 16] = wd;
        exp_lat = wr ? 5 : (hit ? 1 : 7);

        cpu_read    = rd;
        cpu_write   = wr;
        cpu_address = a;
        cpu_wdata   = wd;
        do begin
            @(negedge clk);
            cyc++;
            if (d_readM) nrd++;
            if (d_readM && d_writeM) both++;
            if (d_writeM) begin
                nwr++;
                check({tag, ".wline"}, d_data, exp_line);
            end
            got = cpu_rdata;
        end while (!cpu_ready && cyc < 20);

        check({tag, ".lat"}, 64'(cyc), 64'(exp_lat));
        if (!wr) check({tag, ".rdata"}, 64'(got), 64'(ref_mem[a[7:0]]));
        check({tag, ".nreadM"}, 64'(nrd), 64'((!wr && !hit) ? 4 : 0));
        check({tag, ".nwriteM"}, 64'(nwr), 64'(wr ? 1 : 0));
        check({tag, ".excl"}, 64'(both), 64'd0);

        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;

        if (wr) begin
            ref_mem[a[7:0]] = wd;
            check({tag, ".memwr"}, 64'(mem[a[7:0]]), 64'(wd));
        end else if (hit) begin
            mhits++;
        end else begin
            mmiss++;
            mvalid[idx] = 1'b1;
            mtag[idx]   = a[15:4];
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 64'(cpu_ready), 64'd0);
        check("rst.readM", 64'(d_readM), 64'd0);
        check("rst.writeM", 64'(d_writeM), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Cold miss then hit in the same line
        access(1'b1, 1'b0, 16'h0001, 16'h0, "r0001");
        access(1'b1, 1'b0, 16'h0002, 16'h0, "r0002");
`ifdef DCACHE_STATS_EN
        check("stat.hits", 64'(hit_count), 64'(mhits));
        check("stat.miss", 64'(miss_count), 64'(mmiss));
`endif

        // Conflicting tags on index 0
        access(1'b1, 1'b0, 16'h0000, 16'h0, "r0000a");
        access(1'b1, 1'b0, 16'h0010, 16'h0, "r0010");
        access(1'b1, 1'b0, 16'h0000, 16'h0, "r0000b");

        // Write hit, then read back
        access(1'b0, 1'b1, 16'h0001, 16'h1234, "w0001");
        access(1'b1, 1'b0, 16'h0001, 16'h0, "r0001b");

        // Write miss leaves index 0 untouched; then read the written word
        access(1'b0, 1'b1, 16'h0020, 16'hBEEF, "w0020");
        access(1'b1, 1'b0, 16'h0001, 16'h0, "r0001c");
        access(1'b1, 1'b0, 16'h0020, 16'h0, "r0020");

        // Read+write together behaves as a write
        access(1'b1, 1'b1, 16'h0022, 16'h5A5A, "rw0022");
        access(1'b1, 1'b0, 16'h0022, 16'h0, "r0022");

        // Reset in the middle of a fill
        cpu_read    = 1'b1;
        cpu_address = 16'h0030;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("rstfill.readM", 64'(d_readM), 64'd0);
        check("rstfill.ready", 64'(cpu_ready), 64'd0);
        check("rstfill.writeM", 64'(d_writeM), 64'd0);
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
`ifdef DCACHE_STATS_EN
        check("stat.rst", 64'({hit_count, miss_count}), 64'd0);
`endif
        access(1'b1, 1'b0, 16'h0000, 16'h0, "r0000c");
        access(1'b1, 1'b0, 16'h0030, 16'h0, "r0030");

        // Random traffic, back to back
        for (int n = 0; n < 250; n++) begin
            logic [15:0] a;
            logic [15:0] wd;
            int          op;
            a  = 16'($urandom_range(0, 255));
            wd = 16'($urandom);
            op = int'($urandom_range(0, 3));
            case (op)
                0, 1:    access(1'b1, 1'b0, a, wd, "rnd.rd");
                2:       access(1'b0, 1'b1, a, wd, "rnd.wr");
                default: access(1'b1, 1'b1, a, wd, "rnd.rw");
            endcase
        end
`ifdef DCACHE_STATS_EN
        check("stat.hits.end", 64'(hit_count), 64'(mhits));
        check("stat.miss.end", 64'(miss_count), 64'(mmiss));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
